serial_alu_sequencer: RTL and testbench

Bit-serial N-bit ALU controller built around a single `one_bit_ALU` cell. It latches two WIDTH-bit operands and an opcode, then steps the cell once per clock, LSB first, feeding each cycle's carry back into the next. The result is assembled in a shift register, and completion is signalled with a one-cycle `done` pulse. It sits between a requesting FSM or processor stub and the one-bit datapath, trading latency for area.

---
 rtl/serial_alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial WIDTH-bit AND/OR/ADD(/SUB) sequencer that
// steps a single one_bit_ALU cell once per clock, LSB first.
// Optional feature macro: SERIAL_ALU_SUB_EN (op 11 computes A - B).
// Ports: i_clk, i_rst_n (sync, active-low), i_start, i_op[1:0], i_a_in,
//        i_b_in, i_cin -> o_busy, o_done, o_result[WIDTH-1:0], o_carry_out.

module one_bit_ALU (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic [1:0] i_sel,
    output logic       o_res,
    output logic       o_cout
);
    always_comb begin
        o_res  = 1'b0;
        o_cout = 1'b0;
        case (i_sel)
            2'b00: o_res = i_a & i_b;
            2'b01: o_res = i_a | i_b;
            2'b10: begin
                o_res  = i_a ^ i_b ^ i_cin;
                o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
            end
            default: begin
                o_res  = 1'b0;
                o_cout = 1'b0;
            end
        endcase
    end
endmodule

module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a_in,
    input  logic [WIDTH-1:0] i_b_in,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result_sr;
    logic [1:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_bit_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_b_bit;
    logic [1:0]       w_sel;
    logic             w_res;
    logic             w_cout;
    logic             w_keep_carry;
    logic             w_init_carry;

    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_bit_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ALU_SUB_EN
    // Subtraction is A + ~B + 1 through the adder path.
    assign w_b_bit      = (r_op == 2'b11) ? ~r_b[0] : r_b[0];
    assign w_sel        = (r_op == 2'b11) ? 2'b10 : r_op;
    assign w_keep_carry = r_op[1];
    assign w_init_carry = (i_op == 2'b11) ? 1'b1 :
                          (i_op == 2'b10) ? i_cin : 1'b0;
`else
    // Reserved op 11 reaches the cell unchanged, which outputs 0.
    assign w_b_bit      = r_b[0];
    assign w_sel        = r_op;
    assign w_keep_carry = (r_op == 2'b10);
    assign w_init_carry = (i_op == 2'b10) ? i_cin : 1'b0;
`endif

    one_bit_ALU u_cell (
        .i_a    (r_a[0]),
        .i_b    (w_b_bit),
        .i_cin  (r_carry),
        .i_sel  (w_sel),
        .o_res  (w_res),
        .o_cout (w_cout)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        o_busy = (r_state == S_RUN);
        o_done = (r_state == S_DONE);
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 2'b00;
            r_carry     <= 1'b0;
            r_bit_cnt   <= '0;
            r_result_sr <= '0;
            o_result    <= '0;
            o_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a       <= i_a_in;
            r_b       <= i_b_in;
            r_op      <= i_op;
            r_carry   <= w_init_carry;
            r_bit_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_result_sr <= {w_res, r_result_sr[WIDTH-1:1]};
            r_a         <= r_a >> 1;
            r_b         <= r_b >> 1;
            r_carry     <= w_cout;
            r_bit_cnt   <= r_bit_cnt + 1'b1;
            // Final bit goes straight into the result alongside the shifted bits.
            if (w_last) begin
                o_result    <= {w_res, r_result_sr[WIDTH-1:1]};
                o_carry_out <= w_keep_carry & w_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: directed self-checking bench for
// serial_alu_sequencer at WIDTH=8 (honours SERIAL_ALU_SUB_EN if defined).
module tb_serial_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_alu_sequencer #(.WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_op        (op),
        .i_a_in      (a),
        .i_b_in      (b),
        .i_cin       (cin),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_carry_out (carry_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; runs until done or timeout.
    // poke_at > 0 pulses a stray start with new operands mid-run.
    task automatic wait_done(input string tag, input int poke_at,
                             input logic [7:0] exp_res, input logic exp_co);
        int cyc;
        int nbusy;
        logic [7:0] held;
        logic moved;
        cyc   = 0;
        nbusy = 0;
        moved = 1'b0;
        held  = result;
        while (!done && cyc < 30) begin
            if (busy) nbusy++;
            if (result !== held) moved = 1'b1;
            tick();
            cyc++;
            if (cyc == poke_at) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
                op    = 2'b01;
            end else if (poke_at > 0 && cyc == poke_at + 1) begin
                start = 1'b0;
            end
        end
        chk({tag, "_latency"}, cyc, 8);
        chk({tag, "_busy_cycles"}, nbusy, 8);
        chk({tag, "_result_stable"}, {31'd0, moved}, 0);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        chk({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
        chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_co});
    endtask

    task automatic go(input logic [1:0] o, input logic [7:0] va,
                      input logic [7:0] vb, input logic c);
        op    = o;
        a     = va;
        b     = vb;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst_carry", {31'd0, carry_out}, 0);
        rst_n = 1'b1;
        tick();

        // ADD with wrap-around carry
        go(2'b10, 8'hFF, 8'h01, 1'b0);
        chk("add_busy_e0", {31'd0, busy}, 1);
        wait_done("add_ff01", 0, 8'h00, 1'b1);
        tick();
        chk("add_done_pulse", {31'd0, done}, 0);

        // AND then OR back-to-back, start held high throughout
        op    = 2'b00;
        a     = 8'hF0;
        b     = 8'h3C;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        wait_done("and", 0, 8'h30, 1'b0);
        op = 2'b01;
        tick();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 1);
        wait_done("or", 0, 8'hFC, 1'b0);
        tick();

        // Stray start mid-run is ignored
        go(2'b10, 8'h12, 8'h34, 1'b0);
        wait_done("add_poke", 3, 8'h46, 1'b0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("poke_single_done", ndone, 0);
        chk("poke_idle", {31'd0, busy}, 0);

        // Reset in the middle of a run
        go(2'b10, 8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_result", {24'd0, result}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);

        // ADD with carry-in after reset
        go(2'b10, 8'h7F, 8'h00, 1'b1);
        wait_done("add_cin", 0, 8'h80, 1'b0);
        tick();

        // Op 11
`ifdef SERIAL_ALU_SUB_EN
        go(2'b11, 8'h05, 8'h07, 1'b0);
        wait_done("sub", 0, 8'hFE, 1'b0);
        tick();
        go(2'b11, 8'h07, 8'h05, 1'b0);
        wait_done("sub_nb", 0, 8'h02, 1'b1);
`else
        go(2'b11, 8'h05, 8'h07, 1'b0);
        wait_done("rsvd", 0, 8'h00, 1'b0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
